// File: rtl/tt_extract.sv
// rtl/tt_extract.sv - sequential truth-table extractor for a 7-input single-output network
module tt_extract #(
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    output logic         x0,
    output logic         x1,
    output logic         x2,
    output logic         x3,
    output logic         x4,
    output logic         x5,
    output logic         x6,
    input  logic         f_in,
    input  logic [127:0] exp_tt,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic [127:0] tt,
    output logic [7:0]   ones,
    output logic         match
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    // With no settle time every vector goes straight to its sample cycle.
    localparam state_t FIRST_STATE = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;

    state_t       state_q, state_d;
    logic [6:0]   idx_q, idx_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] tt_q, tt_d;
    logic [7:0]   ones_q, ones_d;
    logic         match_q, match_d;
    logic         aborted_q, aborted_d;
    logic [127:0] tt_next;
    logic [6:0]   x_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            tt_q      <= '0;
            ones_q    <= '0;
            match_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            tt_q      <= tt_d;
            ones_q    <= ones_d;
            match_q   <= match_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        tt_d      = tt_q;
        ones_d    = ones_q;
        match_d   = match_q;
        aborted_d = 1'b0;
        tt_next   = tt_q;
        tt_next[idx_q] = f_in;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = FIRST_STATE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    ones_d  = '0;
                    match_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    match_d   = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_SAMPLE: begin
                // Abort wins over the sample taken on the same edge.
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    match_d   = 1'b0;
                end else begin
                    tt_d   = tt_next;
                    ones_d = ones_q + 8'(f_in);
                    cnt_d  = '0;
                    if (idx_q == 7'd127) begin
                        state_d = S_DONE;
                        match_d = (tt_next == exp_tt);
                    end else begin
                        state_d = FIRST_STATE;
                        idx_d   = idx_q + 7'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign done    = (state_q == S_DONE);
    assign aborted = aborted_q;
    assign tt      = tt_q;
    assign ones    = ones_q;
    assign match   = match_q;
    assign x_vec   = busy ? idx_q : 7'd0;
    assign {x6, x5, x4, x3, x2, x1, x0} = x_vec;

endmodule

// File: tb/tb_tt_extract.sv
// tb/tb_tt_extract.sv - scoreboard bench for tt_extract with SETTLE = 1, 0 and 3
module tb_tt_extract;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         start_v   [3];
    logic         abort_v   [3];
    logic         busy_v    [3];
    logic         done_v    [3];
    logic         aborted_v [3];
    logic         match_v   [3];
    logic [6:0]   x_v       [3];
    logic [127:0] tt_v      [3];
    logic [127:0] exp_v     [3];
    logic [7:0]   ones_v    [3];
    int           mode;

    function automatic logic net_fn(int md, logic [6:0] x);
        case (md)
            0:       return x[0];
            1:       return x[6];
            2:       return &x;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int st_of(int i);
        return (i == 0) ? 1 : (i == 1) ? 0 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        logic [6:0] xg;
        logic       fg;
        assign fg     = net_fn(mode, xg);
        assign x_v[g] = xg;
        tt_extract #(.SETTLE(ST)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .start   (start_v[g]),
            .abort   (abort_v[g]),
            .x0      (xg[0]),
            .x1      (xg[1]),
            .x2      (xg[2]),
            .x3      (xg[3]),
            .x4      (xg[4]),
            .x5      (xg[5]),
            .x6      (xg[6]),
            .f_in    (fg),
            .exp_tt  (exp_v[g]),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .aborted (aborted_v[g]),
            .tt      (tt_v[g]),
            .ones    (ones_v[g]),
            .match   (match_v[g])
        );
    end

    typedef struct {
        int           inst;
        bit           is_abort;
        logic [127:0] tt;
        logic [7:0]   ones;
        logic         m;
        int           cyc;
    } item_t;

    item_t sbq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(int inst, bit ab, logic [127:0] t, logic [7:0] o, logic m, int c);
        item_t it;
        it.inst = inst; it.is_abort = ab; it.tt = t; it.ones = o; it.m = m; it.cyc = c;
        sbq.push_back(it);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && (done_v[i] || aborted_v[i])) begin
                if (sbq.size() == 0) begin
                    chk($sformatf("unexpected_pulse_inst%0d", i), {done_v[i], aborted_v[i]}, 0);
                end else begin
                    item_t it;
                    it = sbq.pop_front();
                    chk("inst", i, it.inst);
                    chk("done", done_v[i], !it.is_abort);
                    chk("aborted", aborted_v[i], it.is_abort);
                    chk("busy_at_end", busy_v[i], 0);
                    chk("tt", tt_v[i], it.tt);
                    chk("ones", ones_v[i], it.ones);
                    chk("match", match_v[i], it.m);
                    chk("end_cycle", cyc, it.cyc);
                end
            end
        end
    end

    task automatic accept(int inst, output int t0);
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start_v[inst] = 1'b0;
        chk("busy_after_accept", busy_v[inst], 1);
    endtask

    task automatic run(int inst, int md, logic [127:0] ev, logic [127:0] et, logic [7:0] eo, logic em);
        int t0;
        mode = md;
        exp_v[inst] = ev;
        accept(inst, t0);
        push(inst, 1'b0, et, eo, em, t0 + 128 * (st_of(inst) + 1));
    endtask

    task automatic drain(int limit);
        for (int k = 0; k < limit && sbq.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    localparam logic [127:0] ALL_A   = {32{4'hA}};
    localparam logic [127:0] TOP_HALF = {{64{1'b1}}, {64{1'b0}}};

    initial begin
        int t0, t1, n;
        rst = 1'b1;
        mode = 0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; exp_v[i] = '0;
        end
        #12;
        chk("rst_tt", tt_v[0], 0);
        chk("rst_ones", ones_v[0], 0);
        chk("rst_busy", busy_v[0], 0);
        chk("rst_x", x_v[0], 0);
        chk("rst_done", done_v[0], 0);
        @(negedge clk);
        rst = 1'b0;

        // f = x0, SETTLE=1; a stray start mid-sweep must be ignored
        run(0, 0, ALL_A, ALL_A, 8'd64, 1'b1);
        repeat (20) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        drain(400);
        repeat (5) @(negedge clk);
        chk("hold_tt", tt_v[0], ALL_A);
        chk("hold_ones", ones_v[0], 64);
        chk("hold_match", match_v[0], 1);
        chk("idle_x", x_v[0], 0);

        // f = x6, SETTLE=0
        run(1, 1, TOP_HALF, TOP_HALF, 8'd64, 1'b1);
        drain(300);

        // f = AND of all inputs, reference all zero
        run(0, 2, '0, 128'h1 << 127, 8'd1, 1'b0);
        drain(400);

        // f = 1, SETTLE=3, abort on the 10th sample edge
        mode = 3;
        exp_v[2] = '1;
        accept(2, t0);
        push(2, 1'b1, 128'h1FF, 8'd9, 1'b0, t0 + 40);
        repeat (39) @(posedge clk);
        #1;
        abort_v[2] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[2] = 1'b0;
        drain(10);
        chk("abort_idle_busy", busy_v[2], 0);
        // abort in IDLE must not pulse aborted
        @(negedge clk);
        abort_v[2] = 1'b1;
        @(negedge clk);
        abort_v[2] = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset mid-sweep at index 50
        mode = 0;
        exp_v[0] = ALL_A;
        accept(0, t0);
        n = 0;
        while (x_v[0] != 7'd50 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx50", x_v[0], 50);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_tt", tt_v[0], 0);
        chk("arst_ones", ones_v[0], 0);
        chk("arst_busy", busy_v[0], 0);
        chk("arst_x", x_v[0], 0);
        chk("arst_match", match_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 0, ALL_A, ALL_A, 8'd64, 1'b1);
        drain(400);

        // start held high across two sweeps, f = 1
        mode = 3;
        exp_v[0] = '1;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        push(0, 1'b0, '1, 8'd128, 1'b1, t0 + 256);
        n = 0;
        while (busy_v[0] && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        while (!busy_v[0] && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        t1 = cyc;
        chk("reaccept_gap", t1 - t0, 258);
        chk("reaccept_tt_clear", tt_v[0], 0);
        chk("reaccept_ones_clear", ones_v[0], 0);
        start_v[0] = 1'b0;
        push(0, 1'b0, '1, 8'd128, 1'b1, t1 + 256);
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_extract.md
TT_EXTRACT -- requirements
Module: tt_extract

Purpose: sequential truth-table extractor. Sweeps all 128 input vectors through an attached 7-input single-output combinational network, samples its output, and returns the 128-bit truth table, its weight, and a compare flag.

Interface
REQ-001 SHALL have parameter SETTLE, default 1, meaning cycles of settle time between driving a vector and sampling; legal range 0..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, sweep request; sampled only in IDLE.
REQ-005 SHALL have port abort, input, 1, terminates a sweep in progress.
REQ-006 SHALL have ports x0..x6, output, 1 each, drive the network inputs; x0 is the index LSB and x6 the MSB.
REQ-007 SHALL have port f_in, input, 1, network output.
REQ-008 SHALL have port expect, input, 128, reference table; must be stable while busy.
REQ-009 SHALL have port busy, output, 1, high from start acceptance until the last sample edge.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port aborted, output, 1, one-cycle abort pulse.
REQ-012 SHALL have port tt, output, 128, truth table; tt[i] is f_in sampled with index i driven (tt[127] is the leftmost hex digit).
REQ-013 SHALL have port ones, output, 8, count of 1s in tt (0..128).
REQ-014 SHALL have port match, output, 1, registered tt==expect.

Function
REQ-015 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE.
REQ-016 SHALL make these transitions: IDLE->SETTLE on start; SETTLE->SAMPLE after SETTLE cycles (direct when SETTLE=0); SAMPLE->SETTLE with index+1 if index<127; SAMPLE->DONE if index==127; DONE->IDLE unconditionally.
REQ-017 SHALL, on start acceptance at edge E0, clear tt, ones and match, set index=0, and assert busy.
REQ-018 SHALL drive vector k from edge E0+k*(SETTLE+1) and sample f_in into tt[k] at edge E0+(k+1)*(SETTLE+1).
REQ-019 SHALL increment ones, saturating-free (8 bits suffice), on each sample with f_in=1.
REQ-020 SHALL deassert busy and assert done for exactly the one cycle after the final sample edge E0+128*(SETTLE+1); tt, ones and match are valid in that cycle.
REQ-021 SHALL update match at the final sample edge, comparing the completed tt (including bit 127) against expect.
REQ-022 SHALL hold tt, ones and match after done until the next start acceptance.
REQ-023 SHALL ignore start while busy or in DONE; start must be high in IDLE to be accepted.
REQ-024 SHALL, on abort while busy, go to IDLE at the next edge, pulse aborted for one cycle, never pulse done, keep the partial tt and ones, and force match=0.
REQ-025 SHALL give abort priority over a coincident sample: the sample at that edge is discarded.
REQ-026 SHALL ignore abort in IDLE or DONE.
REQ-027 SHALL hold x0..x6 at 0 in IDLE and DONE, and drive them equal to index bits [0..6] during SETTLE and SAMPLE.

Reset
REQ-028 SHALL, on rst assertion, immediately force state=IDLE, index=0, x0..x6=0, busy=0, done=0, aborted=0, tt=0, ones=0, match=0, including mid-sweep; no pulse is produced.
REQ-029 SHALL not accept start before the first rising edge after rst deasserts.

Verification
REQ-030 f_in=x0, SETTLE=1, expect=128'hAAAA..AA (all A) -> done exactly 256 cycles after the accept edge; tt=128'hAAAA..AA; ones=64; match=1.
REQ-031 f_in=x6, SETTLE=0 -> done 128 cycles after accept; tt=128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000; ones=64.
REQ-032 f_in=AND(x0..x6), expect=0 -> tt=128'h8000..0000; ones=1; match=0.
REQ-033 f_in=1, SETTLE=3, abort at the 10th sample edge -> aborted pulse, no done; tt[8:0]=9'h1FF with bits above 8 =0; ones=9; match=0.
REQ-034 rst pulsed mid-sweep at index 50 -> all outputs 0 asynchronously; a following start yields a full correct sweep.
REQ-035 start held high continuously -> busy and done alternate; each sweep restarts with cleared tt; no start is accepted during busy or done.
